// File: rtl/tmds_decoder.sv
`timescale 1ns/1ps
// tmds_decoder
// Receive-side TMDS channel decoder. It takes one 10-bit symbol per pixclk from the
// per-channel deserializer. It recovers video data, control data and data-enable, and it
// aligns the symbol boundary using control tokens. While unaligned it asks the
// deserializer to slip one bit.
//
// Ports
//   pixclk   in   1   pixel clock, rising edge
//   rst_n    in   1   synchronous reset, active low
//   TMDS_in  in   10  received symbol, bit 9 is the encoder's inversion flag
//   VD       out  8   decoded video data
//   CD       out  2   decoded control data {vsync,hsync}
//   VDE      out  1   video data enable
//   locked   out  1   word alignment achieved
//   bitslip  out  1   one-cycle request to shift deserializer alignment by one bit
module tmds_decoder #(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int SLIP_HOLDOFF   = 16,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       pixclk,
  input  logic       rst_n,
  input  logic [9:0] TMDS_in,
  output logic [7:0] VD,
  output logic [1:0] CD,
  output logic       VDE,
  output logic       locked,
  output logic       bitslip
);

  localparam int TOK_W  = $clog2(LOCK_COUNT + 1);
  localparam int IDLE_W = $clog2(SEARCH_TIMEOUT + 1);
  localparam int HOLD_W = $clog2(SLIP_HOLDOFF + 1);
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [TOK_W-1:0]  TOK_LAST  = TOK_W'(LOCK_COUNT - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(SEARCH_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SLIP_HOLDOFF - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    HOLDOFF = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t            state;
  logic [TOK_W-1:0]  tok_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [LOSS_W-1:0] loss_cnt;

  logic       is_token;
  logic [1:0] tok_cd;
  logic [7:0] q;
  logic [7:0] dec_vd;

  logic       s1_token;
  logic [1:0] s1_cd;
  logic [7:0] s1_vd;

  logic       lock_next;

  // Classify the incoming symbol and decode it as data in parallel. Tokens are an exact
  // 10-bit match only. The data path first undoes the optional inversion (bit 9). Then it
  // undoes the XOR/XNOR chain, which bit 8 selects.
  always_comb begin
    is_token = 1'b1;
    tok_cd   = 2'b00;
    q        = 8'h00;
    dec_vd   = 8'h00;
    case (TMDS_in)
      10'b1101010100: tok_cd = 2'b00;
      10'b0010101011: tok_cd = 2'b01;
      10'b0101010100: tok_cd = 2'b10;
      10'b1010101011: tok_cd = 2'b11;
      default:        is_token = 1'b0;
    endcase
    q         = TMDS_in[9] ? ~TMDS_in[7:0] : TMDS_in[7:0];
    dec_vd[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      dec_vd[i] = TMDS_in[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  // Stage 1: register the classification and the decoded data. Both the FSM and the
  // output stage work from these registered values, which keeps them in step.
  always_ff @(posedge pixclk) begin
    if (!rst_n) begin
      s1_token <= 1'b0;
      s1_cd    <= 2'b00;
      s1_vd    <= 8'h00;
    end else begin
      s1_token <= is_token;
      s1_cd    <= tok_cd;
      s1_vd    <= dec_vd;
    end
  end

  // Lock state that the coming edge will establish. The FSM and the output gate both use
  // this one signal. As a result, locked and the gated outputs always change on the same
  // edge. A token seen in LOCKED always keeps lock, so a token beats a coincident loss
  // timeout.
  always_comb begin
    lock_next = 1'b0;
    case (state)
      SEARCH:  lock_next = s1_token && (tok_cnt >= TOK_LAST);
      LOCKED:  lock_next = s1_token || (loss_cnt < LOSS_LAST);
      default: lock_next = 1'b0;
    endcase
  end

  // Word-alignment FSM. SEARCH counts consecutive tokens toward lock, and it counts idle
  // cycles toward a bitslip request. HOLDOFF gives the deserializer time to settle after
  // a slip. LOCKED watches for prolonged token absence. Every counter increment is
  // bounded by its terminal compare, so no counter can wrap. bitslip defaults low every
  // cycle, so it is only ever a single-cycle pulse. Reset also kills any pulse.
  always_ff @(posedge pixclk) begin
    if (!rst_n) begin
      state    <= SEARCH;
      tok_cnt  <= '0;
      idle_cnt <= '0;
      hold_cnt <= '0;
      loss_cnt <= '0;
      locked   <= 1'b0;
      bitslip  <= 1'b0;
    end else begin
      bitslip <= 1'b0;
      locked  <= lock_next;
      case (state)
        SEARCH: begin
          if (s1_token) begin
            idle_cnt <= '0;
            if (lock_next) begin
              state    <= LOCKED;
              tok_cnt  <= '0;
              loss_cnt <= '0;
            end else if (tok_cnt < TOK_LAST) begin
              tok_cnt <= tok_cnt + 1'b1;
            end
          end else begin
            tok_cnt <= '0;
            if (idle_cnt >= IDLE_LAST) begin
              bitslip  <= 1'b1;
              state    <= HOLDOFF;
              idle_cnt <= '0;
              hold_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        HOLDOFF: begin
          if (hold_cnt >= HOLD_LAST) begin
            state    <= SEARCH;
            hold_cnt <= '0;
            idle_cnt <= '0;
            tok_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (s1_token) begin
            loss_cnt <= '0;
          end else if (!lock_next) begin
            state    <= SEARCH;
            loss_cnt <= '0;
            tok_cnt  <= '0;
            idle_cnt <= '0;
          end else begin
            loss_cnt <= loss_cnt + 1'b1;
          end
        end
        default: begin
          state    <= SEARCH;
          tok_cnt  <= '0;
          idle_cnt <= '0;
          hold_cnt <= '0;
          loss_cnt <= '0;
        end
      endcase
    end
  end

  // Stage 2: output registers. Everything is forced to zero whenever the edge leaves us
  // unlocked. CD is only updated by tokens, so it holds across data periods.
  always_ff @(posedge pixclk) begin
    if (!rst_n) begin
      VD  <= 8'h00;
      CD  <= 2'b00;
      VDE <= 1'b0;
    end else if (!lock_next) begin
      VD  <= 8'h00;
      CD  <= 2'b00;
      VDE <= 1'b0;
    end else if (s1_token) begin
      VD  <= 8'h00;
      CD  <= s1_cd;
      VDE <= 1'b0;
    end else begin
      VD  <= s1_vd;
      VDE <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
`timescale 1ns/1ps
// tb_tmds_decoder
// Directed scoreboard bench for tmds_decoder. Each stimulus cycle may push the outputs
// expected after the edge that follows its sampling edge (two-cycle latency). A monitor
// pops and compares those entries as the DUT produces them.
module tb_tmds_decoder;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;

  logic       pixclk;
  logic       rst_n;
  logic [9:0] TMDS_in;
  logic [7:0] VD;
  logic [1:0] CD;
  logic       VDE;
  logic       locked;
  logic       bitslip;

  typedef struct {
    int         stamp;
    logic [7:0] vd;
    logic [1:0] cd;
    logic       vde;
    logic       lk;
    logic       bs;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;

  tmds_decoder dut (
    .pixclk  (pixclk),
    .rst_n   (rst_n),
    .TMDS_in (TMDS_in),
    .VD      (VD),
    .CD      (CD),
    .VDE     (VDE),
    .locked  (locked),
    .bitslip (bitslip)
  );

  // Free-running pixel clock, 10 ns period
  initial begin
    pixclk = 1'b0;
    forever #5 pixclk = ~pixclk;
  end

  // Drive one cycle of input at the falling edge. If requested, queue the outputs
  // expected one edge after this symbol's sampling edge.
  task automatic applyStimulus(input logic r, input logic [9:0] sym, input logic chk,
                               input logic [7:0] vd, input logic [1:0] cd, input logic vde,
                               input logic lk, input logic bs, input string tag);
    exp_t e;
    rst_n   = r;
    TMDS_in = sym;
    if (chk) begin
      e.stamp = edge_n + 1;
      e.vd    = vd;
      e.cd    = cd;
      e.vde   = vde;
      e.lk    = lk;
      e.bs    = bs;
      e.tag   = tag;
      sb_q.push_back(e);
    end
    @(negedge pixclk);
  endtask

  // Compare every DUT output against one scoreboard entry
  task automatic checkOutput(input exp_t e);
    checks++;
    if ({VD, CD, VDE, locked, bitslip} !== {e.vd, e.cd, e.vde, e.lk, e.bs}) begin
      errors++;
      $display("[TB] FAIL %s (stamp %0d): got VD=%h CD=%b VDE=%b locked=%b bitslip=%b, expected VD=%h CD=%b VDE=%b locked=%b bitslip=%b",
               e.tag, e.stamp, VD, CD, VDE, locked, bitslip, e.vd, e.cd, e.vde, e.lk, e.bs);
    end
  endtask

  // Monitor: 1 ns after each rising edge, check the entries whose symbol was sampled on
  // the previous edge
  initial begin
    forever begin
      @(posedge pixclk);
      edge_n++;
      #1;
      while (sb_q.size() > 0 && sb_q[0].stamp <= edge_n - 1) begin
        mon_e = sb_q.pop_front();
        checkOutput(mon_e);
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin
    rst_n   = 1'b0;
    TMDS_in = 10'h000;
    repeat (3) @(negedge pixclk);

    // Reset state, then lock on eight consecutive CD=00 tokens
    applyStimulus(1'b0, 10'h000, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, "reset");
    for (int i = 1; i <= 8; i++)
      applyStimulus(1'b1, TOK00, 1'b1, 8'h00, 2'b00, 1'b0, (i == 8), 1'b0, "lock_tok00");

    // Data decode while locked
    applyStimulus(1'b1, 10'h100, 1'b1, 8'h00, 2'b00, 1'b1, 1'b1, 1'b0, "data_100");
    applyStimulus(1'b1, 10'h200, 1'b1, 8'hFF, 2'b00, 1'b1, 1'b1, 1'b0, "data_200");
    applyStimulus(1'b1, 10'h1F0, 1'b1, 8'h10, 2'b00, 1'b1, 1'b1, 1'b0, "data_1F0");
    applyStimulus(1'b1, 10'h00F, 1'b1, 8'hEF, 2'b00, 1'b1, 1'b1, 1'b0, "data_00F");
    applyStimulus(1'b1, 10'h30F, 1'b1, 8'h10, 2'b00, 1'b1, 1'b1, 1'b0, "data_30F");

    // All four control tokens, then CD held across data
    applyStimulus(1'b1, TOK00, 1'b1, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, "cd00");
    applyStimulus(1'b1, TOK01, 1'b1, 8'h00, 2'b01, 1'b0, 1'b1, 1'b0, "cd01");
    applyStimulus(1'b1, TOK10, 1'b1, 8'h00, 2'b10, 1'b0, 1'b1, 1'b0, "cd10");
    applyStimulus(1'b1, TOK11, 1'b1, 8'h00, 2'b11, 1'b0, 1'b1, 1'b0, "cd11");
    applyStimulus(1'b1, 10'h155, 1'b1, 8'hFF, 2'b11, 1'b1, 1'b1, 1'b0, "cd_hold_155");
    applyStimulus(1'b1, 10'h0AA, 1'b1, 8'h00, 2'b11, 1'b1, 1'b1, 1'b0, "cd_hold_0AA");

    // Loss of lock: a token clears the loss count, then 4096 data symbols drop lock
    applyStimulus(1'b1, TOK11, 1'b1, 8'h00, 2'b11, 1'b0, 1'b1, 1'b0, "loss_start");
    for (int k = 1; k <= 4096; k++) begin
      if (k == 4096)
        applyStimulus(1'b1, 10'h155, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, "loss_drop");
      else
        applyStimulus(1'b1, 10'h155, 1'b1, 8'hFF, 2'b11, 1'b1, 1'b1, 1'b0, "loss_wait");
    end
    for (int i = 1; i <= 8; i++)
      applyStimulus(1'b1, TOK11, 1'b1, 8'h00, (i == 8) ? 2'b11 : 2'b00, 1'b0, (i == 8), 1'b0, "relock");
    applyStimulus(1'b1, 10'h00F, 1'b1, 8'hEF, 2'b11, 1'b1, 1'b1, 1'b0, "relock_data");

    // Reset mid-lock clears the outputs on the reset edge itself
    applyStimulus(1'b1, 10'h1F0, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, "rst_midlock");
    applyStimulus(1'b0, TOK00, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, "rst_cycle");

    // A broken token run must not lock; a full run of eight afterwards must
    for (int i = 1; i <= 7; i++)
      applyStimulus(1'b1, TOK00, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, "seven_tok");
    applyStimulus(1'b1, 10'h155, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, "break_data");
    for (int i = 1; i <= 8; i++)
      applyStimulus(1'b1, TOK00, 1'b1, 8'h00, 2'b00, 1'b0, (i == 8), 1'b0, "eight_tok");
    applyStimulus(1'b1, 10'h100, 1'b1, 8'h00, 2'b00, 1'b1, 1'b1, 1'b0, "after_lock");
    applyStimulus(1'b1, 10'h100, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, "filler");

    // Search timeout: a pulse after 2048 idle edges, then another after 16 + 2048 more
    applyStimulus(1'b0, 10'h155, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, "slip_reset");
    for (int k = 1; k <= 4120; k++)
      applyStimulus(1'b1, 10'h155, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0,
                    ((k == 2047) || (k == 4111)), "slip_search");

    // Reset during holdoff; no slip may appear afterwards
    applyStimulus(1'b0, 10'h155, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, "rst_holdoff");
    for (int k = 1; k <= 40; k++)
      applyStimulus(1'b1, 10'h155, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, "post_holdoff");

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge pixclk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
